// File: rtl/timer32_sched_pkg.sv
// Shared types and constants for the TIMER32 delay scheduler.
package timer32_sched_pkg;

  // Width of the scheduler state encoding
  localparam int ST_W = 3;

  // Largest number of requesters the scheduler is meant to serve
  localparam int NREQ_MAX = 8;

  // Scheduler FSM states
  typedef enum logic [ST_W-1:0] {
    IDLE,
    ARM,
    RUN,
    DONE,
    ABORT
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after
// the pointer, wrapping around, and reports both one-hot and index forms.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IW-1:0]   idx_o,
  output logic            any_o
);

  logic [IW-1:0] cand;
  logic          found;

  // Scan requesters starting at the pointer and stop at the first one set
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    cand    = '0;
    for (int off = 0; off < NREQ; off++) begin
      cand = IW'((int'(ptr_i) + off) % NREQ);
      if (!found && req_i[cand]) begin
        found          = 1'b1;
        grant_o[cand]  = 1'b1;
        idx_o          = cand;
      end
    end
  end

  assign any_o = found;

endmodule

// File: rtl/timer32_sched.sv
// Shares one TIMER32 core among NREQ one-shot delay requesters. A requester
// is picked round-robin, the core is programmed and cleared, and the owner
// gets a done pulse on compare match or an aborted pulse on cancel.
module timer32_sched
  import timer32_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic               PCLK,
  input  logic               PRESETn,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*32-1:0] req_ticks,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ-1:0]    cancel,
  output logic [NREQ-1:0]    done,
  output logic [NREQ-1:0]    aborted,
  input  logic [31:0]        cfg_pre,
  output logic               busy,
  output logic [IW-1:0]      owner,
  input  logic [31:0]        TMR,
  input  logic               TMROV,
  output logic [31:0]        PRE,
  output logic [31:0]        TMRCMP,
  output logic               TMREN,
  output logic               TMROVCLR
);

  state_e          state_q, state_d;
  logic [IW-1:0]   owner_q;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [31:0]     pre_q;
  logic [31:0]     tmrcmp_q;
  logic [NREQ-1:0] grant;
  logic [IW-1:0]   grant_idx;
  logic            grant_any;
  logic            accept;
  logic [NREQ-1:0] owner_oh;
  logic [IW-1:0]   owner_next;
  logic [31:0]     ticks_arr [NREQ];
  logic            unused_tmr;

  // The core count is observed only; nothing here decides on it
  assign unused_tmr = ^TMR;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_ticks
      assign ticks_arr[gi] = req_ticks[32*gi +: 32];
    end
  endgenerate

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .req_i   (req_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (grant),
    .idx_o   (grant_idx),
    .any_o   (grant_any)
  );

  assign owner_oh   = NREQ'(1) << owner_q;
  assign owner_next = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
  assign busy       = (state_q != IDLE);
  assign owner      = owner_q;
  assign PRE        = pre_q;
  assign TMRCMP     = tmrcmp_q;

  // Next-state and per-state outputs; req_ready is held off while in reset
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    accept    = 1'b0;
    req_ready = '0;
    done      = '0;
    aborted   = '0;
    TMREN     = 1'b0;
    TMROVCLR  = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_any && PRESETn) begin
          accept    = 1'b1;
          req_ready = grant;
          state_d   = ARM;
        end
      end
      ARM: begin
        TMROVCLR = 1'b1;
        state_d  = (tmrcmp_q == 32'd0) ? DONE : RUN;
      end
      RUN: begin
        TMREN = 1'b1;
        if (TMROV) begin
          state_d = DONE;
        end else if (cancel[owner_q]) begin
          state_d = ABORT;
        end
      end
      DONE: begin
        done     = owner_oh;
        TMROVCLR = 1'b1;
        rr_ptr_d = owner_next;
        state_d  = IDLE;
      end
      ABORT: begin
        aborted  = owner_oh;
        TMROVCLR = 1'b1;
        rr_ptr_d = owner_next;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and round-robin pointer registers
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Owner, prescaler and compare value are captured only on accept
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      owner_q  <= '0;
      pre_q    <= '0;
      tmrcmp_q <= '0;
    end else if (accept) begin
      owner_q  <= grant_idx;
      pre_q    <= cfg_pre;
      tmrcmp_q <= ticks_arr[grant_idx];
    end
  end

endmodule

// File: tb/tb_timer32_sched.sv
// Self-checking bench for timer32_sched with a simple TIMER32 core model
// and a scoreboard of expected grants and completions.
module tb_timer32_sched;

  logic         PCLK = 1'b0;
  logic         PRESETn;
  logic [3:0]   req_valid;
  logic [127:0] req_ticks;
  logic [3:0]   req_ready;
  logic [3:0]   cancel;
  logic [3:0]   done;
  logic [3:0]   aborted;
  logic [31:0]  cfg_pre;
  logic         busy;
  logic [1:0]   owner;
  logic [31:0]  TMR;
  logic         TMROV;
  logic [31:0]  PRE;
  logic [31:0]  TMRCMP;
  logic         TMREN;
  logic         TMROVCLR;

  typedef struct {
    logic [3:0] doneMask;
    logic [3:0] abortMask;
  } comp_t;

  comp_t      expComp[$];
  logic [3:0] expGrant[$];

  int checkCount = 0;
  int failCount  = 0;
  int cyc        = 0;

  int acceptCyc        = 0;
  int compCyc          = 0;
  int tmrenRiseCyc     = 0;
  int ovRiseCyc        = 0;
  int setCyc           = 0;
  int prevCompCyc      = 0;
  logic tmrenSinceAccept = 1'b0;
  logic tmrenPrev        = 1'b0;
  logic ovPrev           = 1'b0;
  logic [3:0] monGrant;
  comp_t      monComp;

  logic [31:0] mdlTmr   = 32'd0;
  logic        mdlOv    = 1'b0;
  logic        coreAuto = 1'b1;
  logic        manualOv = 1'b0;

  assign TMR   = mdlTmr;
  assign TMROV = coreAuto ? mdlOv : manualOv;

  timer32_sched #(.NREQ(4), .IW(2)) dut (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .req_valid (req_valid),
    .req_ticks (req_ticks),
    .req_ready (req_ready),
    .cancel    (cancel),
    .done      (done),
    .aborted   (aborted),
    .cfg_pre   (cfg_pre),
    .busy      (busy),
    .owner     (owner),
    .TMR       (TMR),
    .TMROV     (TMROV),
    .PRE       (PRE),
    .TMRCMP    (TMRCMP),
    .TMREN     (TMREN),
    .TMROVCLR  (TMROVCLR)
  );

  always #5 PCLK = ~PCLK;

  // Cycle counter used for latency measurements
  always @(posedge PCLK) cyc <= cyc + 1;

  // TIMER32 core model: counts while enabled, sticky flag on reaching compare
  always @(posedge PCLK) begin
    if (!TMREN) mdlTmr <= 32'd0;
    else        mdlTmr <= mdlTmr + 32'd1;
    if (TMROVCLR)                                  mdlOv <= 1'b0;
    else if (TMREN && (mdlTmr + 32'd1 == TMRCMP)) mdlOv <= 1'b1;
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] reqBits, input logic [3:0] grantMask, input logic abortPlan);
    comp_t c;
    expGrant.push_back(grantMask);
    c.doneMask  = abortPlan ? 4'b0000 : grantMask;
    c.abortMask = abortPlan ? grantMask : 4'b0000;
    expComp.push_back(c);
    req_valid = req_valid | reqBits;
  endtask

  task automatic waitGrant(input string tag);
    logic [3:0] got;
    got = 4'b0000;
    for (int i = 0; i < 60; i++) begin
      @(negedge PCLK);
      if (req_ready != 4'b0000) begin
        got = req_ready;
        break;
      end
    end
    if (got == 4'b0000) checkOutput({tag, "_grant_timeout"}, 0, 1);
    #1;
    @(posedge PCLK);
    #1;
    req_valid = req_valid & ~got;
  endtask

  task automatic waitComp(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge PCLK);
      if ((done != 4'b0000) || (aborted != 4'b0000)) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) checkOutput({tag, "_comp_timeout"}, 0, 1);
    #1;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  // Monitor: pops the scoreboard on each grant and completion pulse
  always @(negedge PCLK) begin
    if (PRESETn) begin
      if (TMREN && !tmrenPrev) tmrenRiseCyc = cyc;
      if (TMREN) tmrenSinceAccept = 1'b1;
      if (TMROV && !ovPrev) ovRiseCyc = cyc;
      if (req_ready != 4'b0000) begin
        acceptCyc        = cyc;
        tmrenSinceAccept = 1'b0;
        checkOutput("pulse_excl", int'(|req_ready) + int'(|done) + int'(|aborted), 1);
        if (expGrant.size() == 0) begin
          checkOutput("grant_unexpected", req_ready, 0);
        end else begin
          monGrant = expGrant.pop_front();
          checkOutput("grant", req_ready, monGrant);
        end
      end
      if ((done != 4'b0000) || (aborted != 4'b0000)) begin
        compCyc = cyc;
        checkOutput("pulse_excl", int'(|req_ready) + int'(|done) + int'(|aborted), 1);
        if (expComp.size() == 0) begin
          checkOutput("comp_unexpected", {done, aborted}, 0);
        end else begin
          monComp = expComp.pop_front();
          checkOutput("done", done, monComp.doneMask);
          checkOutput("aborted", aborted, monComp.abortMask);
        end
        checkOutput("comp_ovclr", TMROVCLR, 1);
        checkOutput("comp_tmren", TMREN, 0);
      end
    end
    tmrenPrev = TMREN;
    ovPrev    = TMROV;
  end

  // Hard stop if something hangs beyond every bounded wait
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    PRESETn   = 1'b0;
    req_valid = 4'b0000;
    req_ticks = '0;
    cancel    = 4'b0000;
    cfg_pre   = 32'd0;
    #1;
    req_valid = 4'b1111;
    #1;
    checkOutput("rst_ready", req_ready, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_owner", owner, 0);
    checkOutput("rst_pre", PRE, 0);
    checkOutput("rst_tmrcmp", TMRCMP, 0);
    checkOutput("rst_en_clr", {TMREN, TMROVCLR, done, aborted}, 0);
    req_valid = 4'b0000;
    waitCycles(3);
    PRESETn = 1'b1;
    waitCycles(2);

    // All four requesters at once, then requester 0 again from its done cycle
    $display("[TB] round-robin sweep");
    req_ticks = {4{32'd5}};
    applyStimulus(4'b0001, 4'b0001, 1'b0);
    applyStimulus(4'b0010, 4'b0010, 1'b0);
    applyStimulus(4'b0100, 4'b0100, 1'b0);
    applyStimulus(4'b1000, 4'b1000, 1'b0);
    for (int k = 0; k < 5; k++) begin
      waitGrant("rr");
      if (k > 0) checkOutput("rr_gap", acceptCyc - prevCompCyc, 1);
      waitComp("rr");
      prevCompCyc = compCyc;
      if (k == 0) applyStimulus(4'b0001, 4'b0001, 1'b0);
    end
    waitCycles(2);

    // Single delay of 10 ticks with fixed latencies and held configuration
    $display("[TB] single delay");
    cfg_pre = 32'hA5A5_0003;
    req_ticks[31:0] = 32'd10;
    applyStimulus(4'b0001, 4'b0001, 1'b0);
    waitGrant("t1");
    checkOutput("t1_pre", PRE, 32'hA5A5_0003);
    checkOutput("t1_tmrcmp", TMRCMP, 10);
    cfg_pre = 32'hFFFF_0000;
    req_ticks[31:0] = 32'd77;
    waitCycles(3);
    checkOutput("t1_busy_owner", {busy, owner}, 3'b100);
    waitComp("t1");
    checkOutput("t1_en_lat", tmrenRiseCyc - acceptCyc, 2);
    checkOutput("t1_ov_time", ovRiseCyc - tmrenRiseCyc, 10);
    checkOutput("t1_done_lat", compCyc - ovRiseCyc, 1);
    waitCycles(3);
    checkOutput("t1_hold_pre", PRE, 32'hA5A5_0003);
    checkOutput("t1_hold_cmp", TMRCMP, 10);
    checkOutput("t1_idle", {busy, TMREN}, 0);

    // Zero ticks on requester 2: no timing, done straight after ARM
    $display("[TB] zero ticks");
    req_ticks[95:64] = 32'd0;
    applyStimulus(4'b0100, 4'b0100, 1'b0);
    waitGrant("t3");
    waitComp("t3");
    checkOutput("t3_no_tmren", tmrenSinceAccept, 0);
    checkOutput("t3_lat", compCyc - acceptCyc, 2);
    waitCycles(2);

    // Cancel by a non-owner is ignored, cancel by the owner aborts
    $display("[TB] cancel");
    req_ticks[63:32] = 32'd1000;
    applyStimulus(4'b0010, 4'b0010, 1'b1);
    waitGrant("t4");
    waitCycles(4);
    cancel = 4'b1000;
    waitCycles(2);
    checkOutput("t4_nonowner", {busy, TMREN, aborted}, 6'b110000);
    cancel = 4'b0010;
    setCyc = cyc;
    waitComp("t4");
    checkOutput("t4_abort_lat", compCyc - setCyc, 1);
    cancel = 4'b0000;
    waitCycles(2);

    // Overflow and owner cancel in the same cycle: done wins
    $display("[TB] overflow beats cancel");
    coreAuto = 1'b0;
    manualOv = 1'b0;
    req_ticks[127:96] = 32'd1000;
    applyStimulus(4'b1000, 4'b1000, 1'b0);
    waitGrant("t5");
    waitCycles(3);
    manualOv = 1'b1;
    cancel   = 4'b1000;
    setCyc   = cyc;
    waitComp("t5");
    checkOutput("t5_done_lat", compCyc - setCyc, 1);
    manualOv = 1'b0;
    cancel   = 4'b0000;
    coreAuto = 1'b1;
    waitCycles(2);

    // Leave the pointer at 3 so a reset that restores it is visible
    req_ticks[95:64] = 32'd3;
    applyStimulus(4'b0100, 4'b0100, 1'b0);
    waitGrant("pre6");
    waitComp("pre6");
    waitCycles(2);

    // Reset during RUN clears everything and the pointer
    $display("[TB] reset mid-run");
    applyStimulus(4'b0010, 4'b0010, 1'b0);
    waitGrant("t6");
    waitCycles(3);
    checkOutput("t6_running", {busy, TMREN, owner}, 4'b1101);
    PRESETn = 1'b0;
    expComp.delete();
    expGrant.delete();
    req_ticks[31:0] = 32'd4;
    applyStimulus(4'b1111, 4'b0001, 1'b0);
    #1;
    checkOutput("t6_rst_busy", busy, 0);
    checkOutput("t6_rst_pulses", {req_ready, done, aborted}, 0);
    checkOutput("t6_rst_core", {TMREN, TMROVCLR}, 0);
    checkOutput("t6_rst_regs", {PRE, TMRCMP}, 0);
    checkOutput("t6_rst_owner", owner, 0);
    waitCycles(2);
    PRESETn = 1'b1;
    waitGrant("t6_after");
    req_valid = 4'b0000;
    waitComp("t6_after");
    waitCycles(3);

    checkOutput("sb_comp_empty", expComp.size(), 0);
    checkOutput("sb_grant_empty", expGrant.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
